// File: rtl/automat_core.sv
// automat_core: coin-operated vending automaton.
// Accepts 1/2/5-unit coins, dispenses one product once the credit reaches
// PRICE, then pays out change as 2-unit and 1-unit coin pulses.
// Optional feature macro: AUTOMAT_EDGE_DET_EN -- when defined, a coin counts
// only on the rising edge of its input; otherwise a coin input that is high
// at a clock edge in IDLE counts once per edge.
// state_dbg mirrors the FSM state register for observation.
module automat_core #(
    parameter int PRICE = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       b1,
    input  logic       b2,
    input  logic       b3,
    output logic       eb1,
    output logic       eb2,
    output logic       ebs,
    output logic [3:0] rest,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VEND   = 2'd1,
        CHANGE = 2'd2
    } state_t;

    localparam logic [3:0] PRICE_U = 4'(PRICE);

    state_t     state;
    logic [3:0] credit;
    logic       c1;
    logic       c2;
    logic       c3;
    logic [3:0] coin_val;
    logic [3:0] sum;

`ifdef AUTOMAT_EDGE_DET_EN
    logic [2:0] hist;

    // Input history runs in every state so a level held through VEND/CHANGE
    // is not seen as a fresh coin when the FSM returns to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= 3'b000;
        end else begin
            hist <= {b3, b2, b1};
        end
    end

    assign c1 = b1 & ~hist[0];
    assign c2 = b2 & ~hist[1];
    assign c3 = b3 & ~hist[2];
`else
    assign c1 = b1;
    assign c2 = b2;
    assign c3 = b3;
`endif

    // One coin per cycle, 5 beats 2 beats 1; the others are dropped.
    always_comb begin
        coin_val = 4'd0;
        if (c3) begin
            coin_val = 4'd5;
        end else if (c2) begin
            coin_val = 4'd2;
        end else if (c1) begin
            coin_val = 4'd1;
        end
    end

    // credit <= PRICE-1 <= 9, so credit + 5 <= 14 never wraps.
    assign sum = credit + coin_val;

    assign state_dbg = state;

    // Main FSM: credit collection, one-cycle dispense, change payout.
    // The payout pulse is issued on the same edge that leaves VEND, and the
    // FSM falls back to IDLE on the edge after rest has reached 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            credit <= 4'd0;
            rest   <= 4'd0;
            eb1    <= 1'b0;
            eb2    <= 1'b0;
            ebs    <= 1'b0;
        end else begin
            eb1 <= 1'b0;
            eb2 <= 1'b0;
            ebs <= 1'b0;
            case (state)
                IDLE: begin
                    if (coin_val != 4'd0) begin
                        if (sum >= PRICE_U) begin
                            credit <= 4'd0;
                            rest   <= sum - PRICE_U;
                            ebs    <= 1'b1;
                            state  <= VEND;
                        end else begin
                            credit <= sum;
                        end
                    end
                end
                VEND, CHANGE: begin
                    // Coins arriving here are ignored.
                    if (rest >= 4'd2) begin
                        eb2   <= 1'b1;
                        rest  <= rest - 4'd2;
                        state <= CHANGE;
                    end else if (rest == 4'd1) begin
                        eb1   <= 1'b1;
                        rest  <= 4'd0;
                        state <= CHANGE;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_automat_core.sv
// Directed bench for automat_core with PRICE=3.
// Observed word per check: {state[1:0], ebs, eb2, eb1, rest[3:0]};
// state encoding IDLE=0, VEND=1, CHANGE=2.
module tb_automat_core;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_VEND   = 2'd1;
    localparam logic [1:0] S_CHANGE = 2'd2;

    logic       clk;
    logic       rst_n;
    logic       b1;
    logic       b2;
    logic       b3;
    logic       eb1;
    logic       eb2;
    logic       ebs;
    logic [3:0] rest;
    logic [1:0] state_dbg;

    int n_checks;
    int n_fail;

    typedef struct {
        logic       b1;
        logic       b2;
        logic       b3;
        logic [1:0] st;
        logic       ebs;
        logic       eb2;
        logic       eb1;
        logic [3:0] rest;
    } vec_t;

    vec_t vecs[$];

    automat_core #(.PRICE(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .b1        (b1),
        .b2        (b2),
        .b3        (b3),
        .eb1       (eb1),
        .eb2       (eb2),
        .ebs       (ebs),
        .rest      (rest),
        .state_dbg (state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] obs();
        return {state_dbg, ebs, eb2, eb1, rest};
    endfunction

    function automatic logic [8:0] mk(input logic [1:0] st, input logic s,
                                      input logic e2, input logic e1,
                                      input logic [3:0] r);
        return {st, s, e2, e1, r};
    endfunction

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got st=%0d ebs=%b eb2=%b eb1=%b rest=%0d, expected st=%0d ebs=%b eb2=%b eb1=%b rest=%0d",
                     name, act[8:7], act[6], act[5], act[4], act[3:0],
                     exp[8:7], exp[6], exp[5], exp[4], exp[3:0]);
        end
    endtask

    // Advance one active edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_coins(input logic v1, input logic v2, input logic v3);
        b1 = v1;
        b2 = v2;
        b3 = v3;
    endtask

    task automatic add(input logic v1, input logic v2, input logic v3,
                       input logic [1:0] st, input logic s, input logic e2,
                       input logic e1, input logic [3:0] r);
        vec_t v;
        v.b1 = v1; v.b2 = v2; v.b3 = v3;
        v.st = st; v.ebs = s; v.eb2 = e2; v.eb1 = e1; v.rest = r;
        vecs.push_back(v);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        set_coins(1'b0, 1'b0, 1'b0);

        // Coins are pulsed for one cycle with idle gaps so the table holds in
        // both level and edge-detect builds. Each row: inputs before the edge,
        // outputs expected just after it.
        add(1,0,0, S_IDLE,   0,0,0, 4'd0); // credit 1
        add(0,0,0, S_IDLE,   0,0,0, 4'd0);
        add(1,0,0, S_IDLE,   0,0,0, 4'd0); // credit 2
        add(0,0,0, S_IDLE,   0,0,0, 4'd0);
        add(1,0,0, S_VEND,   1,0,0, 4'd0); // 3 -> vend, no change
        add(0,0,0, S_IDLE,   0,0,0, 4'd0);
        add(0,1,0, S_IDLE,   0,0,0, 4'd0); // credit 2
        add(0,0,0, S_IDLE,   0,0,0, 4'd0);
        add(0,1,0, S_VEND,   1,0,0, 4'd1); // 4 -> vend, owe 1
        add(0,0,0, S_CHANGE, 0,0,1, 4'd0); // eb1
        add(0,0,0, S_IDLE,   0,0,0, 4'd0);
        add(1,0,1, S_VEND,   1,0,0, 4'd2); // only the 5 counts
        add(0,0,0, S_CHANGE, 0,1,0, 4'd0); // eb2
        add(0,0,0, S_IDLE,   0,0,0, 4'd0);
        add(0,1,0, S_IDLE,   0,0,0, 4'd0); // credit 2
        add(0,0,0, S_IDLE,   0,0,0, 4'd0);
        add(0,0,1, S_VEND,   1,0,0, 4'd4); // 7 -> owe 4
        add(1,0,0, S_CHANGE, 0,1,0, 4'd2); // coin in VEND ignored
        add(0,0,0, S_CHANGE, 0,1,0, 4'd0);
        add(0,1,0, S_IDLE,   0,0,0, 4'd0); // coin in CHANGE ignored
        add(0,0,0, S_IDLE,   0,0,0, 4'd0);
        add(1,0,0, S_IDLE,   0,0,0, 4'd0); // credit 1 (nothing carried over)
        add(0,0,0, S_IDLE,   0,0,0, 4'd0);
        add(0,1,0, S_VEND,   1,0,0, 4'd0); // 3 -> vend
        add(0,0,0, S_IDLE,   0,0,0, 4'd0);
        add(1,1,0, S_IDLE,   0,0,0, 4'd0); // only the 2 counts
        add(0,0,0, S_IDLE,   0,0,0, 4'd0);
        add(1,0,0, S_VEND,   1,0,0, 4'd0); // 2+1 -> vend
        add(0,0,0, S_IDLE,   0,0,0, 4'd0);

        // Reset must clear outputs before any clock edge.
        #2;
        check("reset_async", obs(), mk(S_IDLE, 0, 0, 0, 4'd0));
        step();
        step();
        check("reset_held", obs(), mk(S_IDLE, 0, 0, 0, 4'd0));
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            set_coins(vecs[i].b1, vecs[i].b2, vecs[i].b3);
            step();
            check($sformatf("vec%0d", i), obs(),
                  mk(vecs[i].st, vecs[i].ebs, vecs[i].eb2, vecs[i].eb1, vecs[i].rest));
        end
        set_coins(1'b0, 1'b0, 1'b0);

        // Reset between edges while change is being paid out.
        set_coins(0, 1, 0); step();
        set_coins(0, 0, 0); step();
        set_coins(0, 0, 1); step();
        check("rst_seq_vend", obs(), mk(S_VEND, 1, 0, 0, 4'd4));
        set_coins(0, 0, 0); step();
        check("rst_seq_change", obs(), mk(S_CHANGE, 0, 1, 0, 4'd2));
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_mid_change", obs(), mk(S_IDLE, 0, 0, 0, 4'd0));
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("post_rst_quiet%0d", i), obs(), mk(S_IDLE, 0, 0, 0, 4'd0));
        end

        // First edge after reset release accepts a coin.
        #2;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        set_coins(0, 0, 1);
        step();
        check("first_edge_coin", obs(), mk(S_VEND, 1, 0, 0, 4'd2));
        set_coins(0, 0, 0);
        step();
        check("first_edge_chg", obs(), mk(S_CHANGE, 0, 1, 0, 4'd0));
        step();
        check("first_edge_idle", obs(), mk(S_IDLE, 0, 0, 0, 4'd0));

`ifdef AUTOMAT_EDGE_DET_EN
        // A held 5-unit coin counts once, even after returning to IDLE.
        set_coins(0, 0, 1);
        step();
        check("hold_b3_vend", obs(), mk(S_VEND, 1, 0, 0, 4'd2));
        step();
        check("hold_b3_chg", obs(), mk(S_CHANGE, 0, 1, 0, 4'd0));
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("hold_b3_idle%0d", i), obs(), mk(S_IDLE, 0, 0, 0, 4'd0));
        end
        set_coins(0, 0, 0);
        step();
        check("hold_b3_release", obs(), mk(S_IDLE, 0, 0, 0, 4'd0));
`else
        // A held 1-unit coin counts on every IDLE edge; the VEND edge in
        // between swallows one, so the second vend lands on the 7th edge.
        set_coins(1, 0, 0);
        for (int i = 0; i < 7; i++) begin
            step();
            if (i == 2 || i == 6) begin
                check($sformatf("hold_b1_e%0d", i), obs(), mk(S_VEND, 1, 0, 0, 4'd0));
            end else begin
                check($sformatf("hold_b1_e%0d", i), obs(), mk(S_IDLE, 0, 0, 0, 4'd0));
            end
        end
        set_coins(0, 0, 0);
        step();
        check("hold_b1_release", obs(), mk(S_IDLE, 0, 0, 0, 4'd0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
